// File: rtl/spi_tgt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_tgt_pkg
//  Description : Shared types and constants for the SPI target receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_tgt_pkg;

    // Frame-level FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } tgt_state_e;

    localparam int         FRAME_BITS    = 8;
    localparam logic [7:0] UNDERRUN_BYTE = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/spi_tgt_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_tgt_rx_if
//  Description : SPI pin bus plus RX/TX byte streams and interrupts of the
//                SPI target. slave = target side, master = host/system side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_tgt_rx_if #(
    parameter int SS_NB = 8
);
    logic [SS_NB-1:0] spi_ss_i;
    logic             spi_sclk_i;
    logic             spi_sd_i;
    logic             spi_sd_o;
    logic             spi_sd_oe_o;
    logic [7:0]       rx_data_o;
    logic             rx_valid_o;
    logic             rx_ready_i;
    logic [7:0]       tx_data_i;
    logic             tx_valid_i;
    logic             tx_ready_o;
    logic             intr_rx_o;
    logic             intr_err_o;

    modport slave (
        input  spi_ss_i, spi_sclk_i, spi_sd_i, rx_ready_i, tx_data_i, tx_valid_i,
        output spi_sd_o, spi_sd_oe_o, rx_data_o, rx_valid_o, tx_ready_o,
               intr_rx_o, intr_err_o
    );

    modport master (
        output spi_ss_i, spi_sclk_i, spi_sd_i, rx_ready_i, tx_data_i, tx_valid_i,
        input  spi_sd_o, spi_sd_oe_o, rx_data_o, rx_valid_o, tx_ready_o,
               intr_rx_o, intr_err_o
    );
endinterface
`default_nettype wire

// File: rtl/spi_tgt_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : spi_tgt_fifo
//  Description : Synchronous byte FIFO. Push while full succeeds only when a
//                pop happens in the same cycle; pop while empty is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_tgt_fifo #(
    parameter int DEPTH = 4
) (
    input  wire logic                     clk_i,
    input  wire logic                     rst_ni,
    input  wire logic                     i_push,
    input  wire logic [7:0]               i_data,
    input  wire logic                     i_pop,
    output logic      [7:0]               o_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic      [$clog2(DEPTH):0]   o_count
);
    localparam int c_aw = $clog2(DEPTH);

    logic [7:0]      r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;
    logic            w_pop_ok;
    logic            w_push_ok;

    assign o_full    = (r_count == (c_aw+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    // Storage write; no reset needed, validity is tracked by the count
    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/spi_tgt_rx.sv
`default_nettype none
// ============================================================================
//  Module      : spi_tgt_rx
//  Description : SPI target endpoint (CPOL=0, CPHA=0, 8-bit frames). Pins are
//                oversampled in the clk_i domain; received bytes go to an RX
//                FIFO, response bytes are shifted out on MISO.
//                Macro SPI_TGT_LSB_FIRST_EN selects LSB-first frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_tgt_rx
    import spi_tgt_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SS_IDX     = 0,
    parameter int SS_NB      = 8
) (
    input  wire logic     clk_i,
    input  wire logic     rst_ni,
    spi_tgt_rx_if.slave   bus
);
    localparam int                  c_cnt_w    = $clog2(FRAME_BITS);
    localparam logic [c_cnt_w-1:0]  c_last_bit = c_cnt_w'(FRAME_BITS - 1);

    logic [SS_NB-1:0]          w_ss_bus;
    logic                      w_unused_ss;
    logic [1:0]                r_ss_sync, r_sclk_sync, r_sd_sync;
    logic                      r_sclk_d;
    logic                      w_ss_act, w_rise, w_fall, w_sd;
    tgt_state_e                r_state, w_state_nxt;
    logic                      w_load, w_rx_bit, w_tx_bit, w_frame_done;
    logic [c_cnt_w-1:0]        r_bit_cnt;
    logic [7:0]                r_rx_shift, r_tx_shift, r_tx_hold;
    logic                      r_tx_full, r_sd_o, r_oe, r_fresh, r_err;
    logic [7:0]                w_rx_next, w_tx_shifted, w_load_byte, w_fifo_data;
    logic                      w_load_bit, w_head_bit, w_shift_bit;
    logic                      w_tx_take, w_underrun, w_overrun, w_pop, w_push;
    logic                      w_fifo_full, w_fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] w_fifo_cnt_unused;

    assign w_ss_bus    = bus.spi_ss_i;
    assign w_unused_ss = ^w_ss_bus;

    // Two-flop synchronisers; an extra sclk flop gives edge detection
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ss_sync   <= 2'b11;
            r_sclk_sync <= 2'b00;
            r_sd_sync   <= 2'b00;
            r_sclk_d    <= 1'b0;
        end else begin
            r_ss_sync   <= {r_ss_sync[0], w_ss_bus[SS_IDX]};
            r_sclk_sync <= {r_sclk_sync[0], bus.spi_sclk_i};
            r_sd_sync   <= {r_sd_sync[0], bus.spi_sd_i};
            r_sclk_d    <= r_sclk_sync[1];
        end
    end

    assign w_ss_act = ~r_ss_sync[1];
    assign w_rise   = r_sclk_sync[1] & ~r_sclk_d;
    assign w_fall   = ~r_sclk_sync[1] & r_sclk_d;
    assign w_sd     = r_sd_sync[1];

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // FSM next state and per-cycle datapath strobes; ss release always wins
    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_rx_bit     = 1'b0;
        w_tx_bit     = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            ST_IDLE: if (w_ss_act) w_state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (!w_ss_act) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!w_ss_act) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_rx_bit     = w_rise;
                    w_tx_bit     = w_fall;
                    w_frame_done = w_rise && (r_bit_cnt == c_last_bit);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef SPI_TGT_LSB_FIRST_EN
    assign w_rx_next    = {w_sd, r_rx_shift[7:1]};
    assign w_tx_shifted = {1'b0, r_tx_shift[7:1]};
    assign w_load_bit   = w_load_byte[0];
    assign w_head_bit   = r_tx_shift[0];
    assign w_shift_bit  = r_tx_shift[1];
`else
    assign w_rx_next    = {r_rx_shift[6:0], w_sd};
    assign w_tx_shifted = {r_tx_shift[6:0], 1'b0};
    assign w_load_bit   = w_load_byte[7];
    assign w_head_bit   = r_tx_shift[7];
    assign w_shift_bit  = r_tx_shift[6];
`endif

    assign w_tx_take   = w_load | w_frame_done;
    assign w_load_byte = r_tx_full ? r_tx_hold : UNDERRUN_BYTE;
    assign w_underrun  = w_tx_take & ~r_tx_full;
    assign w_pop       = ~w_fifo_empty & bus.rx_ready_i;
    assign w_overrun   = w_frame_done & w_fifo_full & ~w_pop;
    assign w_push      = w_frame_done & ~w_overrun;

    // TX holding register: captured when empty, emptied when the shifter loads
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_tx_hold <= '0;
            r_tx_full <= 1'b0;
        end else begin
            if (w_tx_take && r_tx_full) r_tx_full <= 1'b0;
            if (bus.tx_valid_i && !r_tx_full) begin
                r_tx_hold <= bus.tx_data_i;
                r_tx_full <= 1'b1;
            end
        end
    end

    // Shift registers and MISO; a byte loaded at frame end is only driven at
    // the following SCLK falling edge (r_fresh), not shifted on it
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_tx_shift <= '0;
            r_sd_o     <= 1'b1;
            r_oe       <= 1'b0;
            r_fresh    <= 1'b0;
        end else if (!w_ss_act) begin
            r_bit_cnt <= '0;
            r_sd_o    <= 1'b1;
            r_oe      <= 1'b0;
            r_fresh   <= 1'b0;
        end else begin
            if (w_load) begin
                r_tx_shift <= w_load_byte;
                r_sd_o     <= w_load_bit;
                r_oe       <= 1'b1;
                r_fresh    <= 1'b0;
                r_bit_cnt  <= '0;
            end
            if (w_rx_bit) begin
                r_rx_shift <= w_rx_next;
                r_bit_cnt  <= w_frame_done ? '0 : r_bit_cnt + 1'b1;
            end
            if (w_frame_done) begin
                r_tx_shift <= w_load_byte;
                r_fresh    <= 1'b1;
            end
            if (w_tx_bit) begin
                if (r_fresh) begin
                    r_sd_o  <= w_head_bit;
                    r_fresh <= 1'b0;
                end else begin
                    r_tx_shift <= w_tx_shifted;
                    r_sd_o     <= w_shift_bit;
                end
            end
        end
    end

    // Single error pulse covers coincident overrun and underrun
    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_err <= 1'b0;
        else         r_err <= w_underrun | w_overrun;
    end

    spi_tgt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_push),
        .i_data  (w_rx_next),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_cnt_unused)
    );

    // MISO is released as soon as the synchronised ss deasserts
    assign bus.spi_sd_o    = r_sd_o | ~w_ss_act;
    assign bus.spi_sd_oe_o = r_oe & w_ss_act;
    assign bus.rx_data_o   = w_fifo_data;
    assign bus.rx_valid_o  = ~w_fifo_empty;
    assign bus.intr_rx_o   = ~w_fifo_empty;
    assign bus.tx_ready_o  = ~r_tx_full;
    assign bus.intr_err_o  = r_err;
endmodule
`default_nettype wire
